// File: rtl/dreg_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit D-flop register among N requesters.
// Each grant loads the winner's data, then holds it stable for HOLD cycles.
module dreg_rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned HOLD = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [W-1:0]   q,
   output logic           q_valid,
   output logic           busy
);

   localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW1 = PW + 1;
   localparam int unsigned CW  = 4;

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [W-1:0]  q_q, q_d;
   logic          qv_q, qv_d;

   logic [N-1:0]  req_eff;
   logic [PW:0]   cand;
   logic          win_found;
   logic [PW-1:0] win_idx;
   logic [W-1:0]  win_data;

   // A requester is ignored on the edge where its own grant is still showing.
   assign req_eff = req & ~gnt_q;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = {1'b0, ptr_q} + PW1'(i);
         if (cand >= PW1'(N)) begin
            cand = cand - PW1'(N);
         end
         if (!win_found && req_eff[cand[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (win_idx == PW'(k)) begin
            win_data = wdata[k*W +: W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      q_d     = q_q;
      qv_d    = qv_q;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               gnt_d[win_idx] = 1'b1;
               q_d            = win_data;
               qv_d           = 1'b1;
               ptr_d          = win_idx;
               if (HOLD > 0) begin
                  state_d = StHold;
                  cnt_d   = CW'(HOLD - 1);
               end
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= PW'(N - 1);
         gnt_q   <= '0;
         q_q     <= '0;
         qv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         q_q     <= q_d;
         qv_q    <= qv_d;
      end
   end

   assign gnt     = gnt_q;
   assign q       = q_q;
   assign q_valid = qv_q;
   assign busy    = (state_q == StHold);

endmodule

// File: doc/dreg_rr_arbiter.md
Name: dreg_rr_arbiter

Overview:
- Round-robin arbiter that shares one W-bit D-flop data register among N requesters.
- Each grant loads the winner's data into the shared register, then holds it stable for HOLD cycles before the next grant.
- Sits between independent producers and a single downstream register consumer; the D-flop storage is built inside this block.

Parameters:
N, 4, number of requesters (2..16)
W, 8, data width of shared register
HOLD, 2, cycles q is held stable after a load before re-arbitration (0..15; 0 = back-to-back grants)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector, one bit per requester, level-sensitive
wdata  input  N*W  requester data, requester k at bits [k*W +: W]
gnt  output  N  registered one-hot grant, high exactly one cycle per load
q  output  W  shared register contents
q_valid  output  1  set on first load, stays 1 until reset
busy  output  1  high while in HOLD state

Behaviour:
- Reset (async, rst_n=0): gnt=0, q=0, q_valid=0, busy=0, state=IDLE, hold counter=0, priority pointer ptr=N-1 so requester 0 has first priority. Takes effect immediately, including mid-HOLD; arbitration restarts from IDLE after release.
- States: IDLE, HOLD.
- IDLE at a clk edge with any unmasked req bit set:
  - Winner k = first set bit searching ptr+1, ptr+2, ... with wrap N-1 -> 0.
  - Registered results: gnt=one-hot(k), q=wdata[k], q_valid=1, ptr=k.
  - If HOLD>0: state=HOLD, counter=HOLD-1, busy=1.
  - If HOLD=0: stay IDLE.
- IDLE with no req: gnt=0, q unchanged.
- HOLD: gnt=0, q stable, busy=1. Counter decrements each edge. At an edge where counter==0: state=IDLE, busy=0. The first new grant can occur at the following edge.
- Latency: req sampled at edge t -> gnt/q visible after edge t (1 cycle). Load-to-load spacing is HOLD+1 cycles minimum.
- Masking: at an edge where gnt[k]=1, req[k] is ignored. A requester drops req after seeing gnt, so with HOLD=0 it is not double-granted. Other requesters are not masked.
- Requester protocol: hold req and wdata stable until gnt. Dropping req before gnt withdraws the request, with no side effects.
- Fairness: any continuously asserted req is granted within N grants.
- gnt is always one-hot or zero, never multi-bit.
- q changes only on edges where gnt≠0 (or on reset).
- wdata of non-winners is ignored.
- All outputs are registered. No combinational path from req/wdata to any output.

Test Plan (N=4, W=8, HOLD=2):
1. Reset, then req=0001, wdata[0]=0xA5 -> after next edge: gnt=0001, q=0xA5, q_valid=1, busy=1. Busy stays high 2 cycles, then IDLE.
2. req=1111 held constant, wdata[k]=0x10+k -> grants in order 0001, 0010, 0100, 1000, 0001, each 3 cycles apart. q steps 0x10, 0x11, 0x12, 0x13, 0x10.
3. Wrap: grant requester 3 (ptr=3), then req=1001 -> next grant is 0001 (wrap to 0), then 1000.
4. Assert rst_n=0 mid-HOLD with q=0x5A -> outputs go to 0 immediately without a clock edge. After release, req=0110 -> gnt=0010 (pointer reset to priority 0 -> 1).
5. HOLD=0 rebuild, req=0011 steady -> gnt alternates 0001/0010 every cycle, busy never 1. A requester that drops req after its gnt receives exactly one grant.
6. Random req/wdata for 1000 cycles -> checker confirms gnt one-hot/zero, q==wdata[k] of the granted k, spacing ≥ HOLD+1, and no starvation beyond N grants.
